// File: rtl/inference_sequencer.sv
// Frame-level sequencer: buffers one pixel frame, waits for the combinational
// network to settle, then serially scans its outputs for the argmax class.
// Optional RESULT_SCORE_EN adds res_score, the winning snapshot value.
//
// state  | meaning
// -------+--------------------------------------------------------------
// LOAD   | accepting pixels into the frame buffer (pix_ready=1)
// SETTLE | buffer frozen, down-counter waits for network propagation
// SCAN   | one snapshot class compared per clock, running best kept
// DONE   | result presented on res_valid/res_class until taken
module inference_sequencer #(
   parameter int N_INPUTS      = 784,
   parameter int N_OUTPUTS     = 10,
   parameter int SETTLE_CYCLES = 4,
   parameter int CLS_W         = $clog2(N_OUTPUTS)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   pix_valid,
   input  logic [7:0]             pix_data,
   output logic                   pix_ready,
   output logic [8*N_INPUTS-1:0]  net_in,
   input  logic [8*N_OUTPUTS-1:0] net_out,
   output logic                   res_valid,
   input  logic                   res_ready,
   output logic [CLS_W-1:0]       res_class,
   output logic                   busy
`ifdef RESULT_SCORE_EN
   ,
   output logic [7:0]             res_score
`endif
);

   localparam int PW = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
   localparam int TW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [PW-1:0]    LAST_PIX    = PW'(N_INPUTS - 1);
   localparam logic [TW-1:0]    SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);
   localparam logic [CLS_W-1:0] LAST_CLS    = CLS_W'(N_OUTPUTS - 1);

   typedef enum logic [1:0] {LOAD, SETTLE, SCAN, DONE} state_t;

   state_t                 state;
   logic [PW-1:0]          pix_cnt;
   logic [TW-1:0]          settle_cnt;
   logic [CLS_W-1:0]       scan_idx;
   logic [CLS_W-1:0]       best_idx;
   logic [CLS_W-1:0]       next_idx;
   logic [7:0]             best_val;
   logic [7:0]             cur_val;
   logic [7:0]             next_val;
   logic [8*N_OUTPUTS-1:0] snap;

   assign pix_ready = (state == LOAD);
   assign res_valid = (state == DONE);
   assign busy      = (state != LOAD);

   // Strict greater-than keeps the lowest index on ties.
   always_comb begin
      cur_val = '0;
      for (int j = 0; j < N_OUTPUTS; j++) begin
         if (scan_idx == CLS_W'(j)) cur_val = snap[8*j +: 8];
      end
      next_val = best_val;
      next_idx = best_idx;
      if (scan_idx == '0 || cur_val > best_val) begin
         next_val = cur_val;
         next_idx = scan_idx;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= LOAD;
         pix_cnt    <= '0;
         settle_cnt <= '0;
         scan_idx   <= '0;
         best_idx   <= '0;
         best_val   <= '0;
         snap       <= '0;
         net_in     <= '0;
         res_class  <= '0;
`ifdef RESULT_SCORE_EN
         res_score  <= '0;
`endif
      end else begin
         case (state)
            LOAD: begin
               if (pix_valid) begin
                  for (int k = 0; k < N_INPUTS; k++) begin
                     if (pix_cnt == PW'(k)) net_in[8*k +: 8] <= pix_data;
                  end
                  if (pix_cnt == LAST_PIX) begin
                     pix_cnt    <= '0;
                     settle_cnt <= SETTLE_LOAD;
                     state      <= SETTLE;
                  end else begin
                     pix_cnt <= pix_cnt + PW'(1);
                  end
               end
            end
            SETTLE: begin
               if (settle_cnt == '0) begin
                  snap     <= net_out;
                  scan_idx <= '0;
                  state    <= SCAN;
               end else begin
                  settle_cnt <= settle_cnt - TW'(1);
               end
            end
            SCAN: begin
               best_val <= next_val;
               best_idx <= next_idx;
               if (scan_idx == LAST_CLS) begin
                  res_class <= next_idx;
`ifdef RESULT_SCORE_EN
                  res_score <= next_val;
`endif
                  state     <= DONE;
               end else begin
                  scan_idx <= scan_idx + CLS_W'(1);
               end
            end
            DONE: begin
               if (res_ready) state <= LOAD;
            end
            default: state <= LOAD;
         endcase
      end
   end

endmodule

// File: tb/tb_inference_sequencer.sv
// Bench for inference_sequencer: a small instance (4/3/2) driven from a vector
// table plus hand-written corner sequences, and a default-size instance.
module tb_inference_sequencer;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // small instance: N_INPUTS=4, N_OUTPUTS=3, SETTLE_CYCLES=2
   logic        s_pix_valid, s_pix_ready, s_res_valid, s_res_ready, s_busy;
   logic [7:0]  s_pix_data;
   logic [31:0] s_net_in;
   logic [23:0] s_net_out;
   logic [1:0]  s_res_class;
   // default instance: 784/10/4
   logic        d_pix_valid, d_pix_ready, d_res_valid, d_res_ready, d_busy;
   logic [7:0]  d_pix_data;
   logic [8*784-1:0] d_net_in;
   logic [79:0] d_net_out;
   logic [3:0]  d_res_class;
`ifdef RESULT_SCORE_EN
   logic [7:0]  s_res_score, d_res_score;
`endif

   inference_sequencer #(.N_INPUTS(4), .N_OUTPUTS(3), .SETTLE_CYCLES(2)) u_small (
      .clk(clk), .rst_n(rst_n),
      .pix_valid(s_pix_valid), .pix_data(s_pix_data), .pix_ready(s_pix_ready),
      .net_in(s_net_in), .net_out(s_net_out),
      .res_valid(s_res_valid), .res_ready(s_res_ready), .res_class(s_res_class),
      .busy(s_busy)
`ifdef RESULT_SCORE_EN
      , .res_score(s_res_score)
`endif
   );

   inference_sequencer u_big (
      .clk(clk), .rst_n(rst_n),
      .pix_valid(d_pix_valid), .pix_data(d_pix_data), .pix_ready(d_pix_ready),
      .net_in(d_net_in), .net_out(d_net_out),
      .res_valid(d_res_valid), .res_ready(d_res_ready), .res_class(d_res_class),
      .busy(d_busy)
`ifdef RESULT_SCORE_EN
      , .res_score(d_res_score)
`endif
   );

   int checks = 0;
   int errors = 0;

   typedef struct { logic [3:0] cls; logic [7:0] score; } exp_t;
   exp_t sb[$];

   typedef struct {
      logic [31:0] px;
      logic [23:0] nout;
      logic [3:0]  cls;
      logic [7:0]  score;
   } vec_t;
   vec_t vt[6];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic pop_check(input string name, input logic [3:0] cls, input logic [7:0] score);
      exp_t e;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s actual=unexpected_result required=none", name);
      end else begin
         e = sb.pop_front();
         check({name, "_class"}, 64'(cls), 64'(e.cls));
`ifdef RESULT_SCORE_EN
         check({name, "_score"}, 64'(score), 64'(e.score));
`else
         if (score != e.score) begin end
`endif
      end
   endtask

   // Drives four back-to-back pixels; checks the old frame is held behind the first write.
   task automatic small_frame(input logic [31:0] px, input logic [31:0] prev);
      for (int k = 0; k < 4; k++) begin
         s_pix_valid = 1'b1;
         s_pix_data  = px[8*k +: 8];
         @(posedge clk);
         @(negedge clk);
         if (k == 0) check("net_in_hold", 64'(s_net_in), 64'({prev[31:8], px[7:0]}));
      end
      s_pix_valid = 1'b0;
   endtask

   // Counts edges after the last accept until res_valid; optionally disturbs net_out after capture.
   task automatic small_wait(input bit perturb, output int n);
      n = 0;
      while (!s_res_valid && n < 60) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (perturb && n == 2) s_net_out = 24'hFFFFFF;
      end
   endtask

   int n;
   int seen;
   int mism;
   int idx;
   int guard;
   logic [7:0]  exp_px[784];
   logic [31:0] prev;

   initial begin
      rst_n = 1'b0;
      s_pix_valid = 1'b0; s_pix_data = '0; s_net_out = '0; s_res_ready = 1'b0;
      d_pix_valid = 1'b0; d_pix_data = '0; d_net_out = '0; d_res_ready = 1'b0;

      vt[0] = '{32'h44332211, 24'h059010, 4'd1, 8'h90};
      vt[1] = '{32'hDEADBEEF, 24'h7F8080, 4'd0, 8'h80};
      vt[2] = '{32'h01020304, 24'hFF0000, 4'd2, 8'hFF};
      vt[3] = '{32'h00000000, 24'h000000, 4'd0, 8'h00};
      vt[4] = '{32'hA5A5A55A, 24'h810080, 4'd2, 8'h81};
      vt[5] = '{32'h5A5A5A5A, 24'h01FF00, 4'd1, 8'hFF};

      repeat (2) @(negedge clk);
      check("rst_pix_ready", 64'(s_pix_ready), 64'd1);
      check("rst_res_valid", 64'(s_res_valid), 64'd0);
      check("rst_busy",      64'(s_busy),      64'd0);
      check("rst_net_in",    64'(s_net_in),    64'd0);
      check("rst_res_class", 64'(s_res_class), 64'd0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_pix_ready", 64'(s_pix_ready), 64'd1);
      check("idle_busy",      64'(s_busy),      64'd0);
      check("idle_res_valid", 64'(s_res_valid), 64'd0);

      prev = '0;
      for (int i = 0; i < 6; i++) begin
         s_net_out   = vt[i].nout;
         s_res_ready = (i % 2 == 1);
         sb.push_back('{vt[i].cls, vt[i].score});
         small_frame(vt[i].px, prev);
         check("vec_net_in", 64'(s_net_in), 64'(vt[i].px));
         check("vec_busy",   64'(s_busy),   64'd1);
         small_wait(1'b1, n);
         check("vec_latency", 64'(n), 64'd5);
         pop_check("vec", 4'(s_res_class),
`ifdef RESULT_SCORE_EN
                   s_res_score);
`else
                   vt[i].score);
`endif
         if (s_res_ready) begin
            @(posedge clk);
            @(negedge clk);
            check("done_one_cycle", 64'(s_res_valid), 64'd0);
         end else begin
            s_res_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            s_res_ready = 1'b0;
         end
         check("vec_back_to_load", 64'(s_pix_ready), 64'd1);
         prev = vt[i].px;
      end

      // backpressure: result held, pixels ignored
      s_res_ready = 1'b0;
      s_net_out   = 24'h30C020;
      sb.push_back('{4'd1, 8'hC0});
      small_frame(32'h0F0E0D0C, prev);
      small_wait(1'b0, n);
      check("bp_latency", 64'(n), 64'd5);
      pop_check("bp", 4'(s_res_class),
`ifdef RESULT_SCORE_EN
                s_res_score);
`else
                8'hC0);
`endif
      for (int c = 0; c < 10; c++) begin
         s_pix_valid = 1'b1;
         s_pix_data  = 8'hAA;
         @(posedge clk);
         @(negedge clk);
         check("bp_res_valid", 64'(s_res_valid), 64'd1);
         check("bp_res_class", 64'(s_res_class), 64'd1);
         check("bp_pix_ready", 64'(s_pix_ready), 64'd0);
         check("bp_net_in",    64'(s_net_in),    64'h0F0E0D0C);
      end
      s_pix_valid = 1'b0;
      s_res_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      s_res_ready = 1'b0;
      check("bp_release_load", 64'(s_pix_ready), 64'd1);
      check("bp_release_busy", 64'(s_busy),      64'd0);

      // asynchronous reset in the middle of SCAN
      s_net_out = 24'h00FF00;
      small_frame(32'h99887766, 32'h0F0E0D0C);
      repeat (3) begin
         @(posedge clk);
         @(negedge clk);
      end
      check("scan_busy", 64'(s_busy), 64'd1);
      rst_n = 1'b0;
      #1;
      check("arst_net_in",    64'(s_net_in),    64'd0);
      check("arst_res_valid", 64'(s_res_valid), 64'd0);
      check("arst_busy",      64'(s_busy),      64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (20) begin
         @(negedge clk);
         if (s_res_valid) seen++;
      end
      check("arst_no_result", 64'(seen), 64'd0);
      sb.push_back('{4'd1, 8'hFF});
      s_res_ready = 1'b1;
      small_frame(32'h13579BDF, 32'h0);
      small_wait(1'b0, n);
      check("arst_fresh_latency", 64'(n), 64'd5);
      pop_check("arst_fresh", 4'(s_res_class),
`ifdef RESULT_SCORE_EN
                s_res_score);
`else
                8'hFF);
`endif
      @(posedge clk);
      @(negedge clk);
      s_res_ready = 1'b0;

      // default-size instance with randomly gapped pixel stream, peak at class 7
      for (int j = 0; j < 10; j++)
         d_net_out[8*j +: 8] = (j == 7) ? 8'hF0 : 8'($urandom_range(0, 239));
      for (int k = 0; k < 784; k++) exp_px[k] = 8'($urandom_range(0, 255));
      sb.push_back('{4'd7, 8'hF0});
      idx = 0;
      guard = 0;
      while (idx < 784 && guard < 20000) begin
         d_pix_valid = 1'($urandom_range(0, 1));
         d_pix_data  = exp_px[idx];
         @(posedge clk);
         if (d_pix_valid) idx++;
         guard++;
         @(negedge clk);
      end
      d_pix_valid = 1'b0;
      check("big_pixels_sent", 64'(idx), 64'd784);
      mism = 0;
      for (int k = 0; k < 784; k++)
         if (d_net_in[8*k +: 8] !== exp_px[k]) mism++;
      check("big_net_in_mismatches", 64'(mism), 64'd0);
      check("big_busy", 64'(d_busy), 64'd1);
      n = 0;
      while (!d_res_valid && n < 100) begin
         @(posedge clk);
         n++;
         @(negedge clk);
      end
      check("big_latency", 64'(n), 64'd14);
      pop_check("big", d_res_class,
`ifdef RESULT_SCORE_EN
                d_res_score);
`else
                8'hF0);
`endif
      d_res_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      d_res_ready = 1'b0;
      check("big_back_to_load", 64'(d_pix_ready), 64'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
